bcd_to_bin_seq: RTL and testbench

Sequential reverse double-dabble converter: accepts a packed multi-digit BCD value and produces its binary equivalent by shifting right one bit per clock and subtracting 3 from any BCD digit ≥ 8. It sits on the soda machine's entry path. Price and credit values held or entered as BCD digits are converted here to binary before the coin and change arithmetic uses them. It is the inverse of the binary-to-BCD display path.

---
 rtl/bcd_to_bin_seq.sv | 180 ++++++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_seq
// Purpose  : Sequential reverse double-dabble converter. A packed multi-digit
//            BCD value is turned into binary by shifting the working register
//            {bcd, bin} right one bit per clock. After each shift, 3 is
//            subtracted from every BCD digit that is >= 8. Used on the soda
//            machine entry path to convert BCD price and credit values into
//            binary for the coin and change arithmetic.
// Ports    : clk      - single clock, rising edge
//            rst_n    - asynchronous active-low reset
//            start    - conversion request, sampled only while idle
//            bcd_in   - packed BCD input, digit 0 in bits [3:0]
//            busy     - conversion in progress
//            done     - one-cycle completion pulse
//            bin_out  - result, held until the next completion
//            err      - invalid BCD digit flag, valid while done=1
// Options  : BCD_CHECK_EN - when defined, a start with any digit > 9 is
//            rejected in one clock with done=1, err=1 and bin_out=0.
//            Without it, err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_cnt_w = $clog2(BIN_W + 1);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(BIN_W - 1);

  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_shift = 1'b1;

  logic [0:0]               r_state;
  logic [0:0]               w_next_state;
  logic [c_bcd_w-1:0]       r_bcd;
  logic [BIN_W-1:0]         r_bin;
  logic [c_cnt_w-1:0]       r_cnt;
  logic                     r_done;
  logic [BIN_W-1:0]         r_bin_out;

  logic [c_bcd_w+BIN_W-1:0] w_shift;
  logic [c_bcd_w-1:0]       w_sh_bcd;
  logic [BIN_W-1:0]         w_sh_bin;
  logic [c_bcd_w-1:0]       w_cor_bcd;
  logic                     w_last;
  logic                     w_bad_digit;

  // Shift the whole working register right 1. A zero enters the bcd MSB,
  // and the bcd LSB falls into the bin MSB.
  assign w_shift  = {r_bcd, r_bin} >> 1;
  assign w_sh_bcd = w_shift[c_bcd_w+BIN_W-1:BIN_W];
  assign w_sh_bin = w_shift[BIN_W-1:0];
  assign w_last   = (r_cnt == c_last_cnt);

  // Per-digit correction. Each digit is handled on its own, with no borrow
  // passed between digits.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] w_d;
      assign w_d = w_sh_bcd[4*i +: 4];
      assign w_cor_bcd[4*i +: 4] = (w_d >= 4'd8) ? (w_d - 4'd3) : w_d;
    end
  endgenerate

`ifdef BCD_CHECK_EN
  logic [DIGITS-1:0] w_digit_bad;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_check
      assign w_digit_bad[i] = (bcd_in[4*i +: 4] > 4'd9);
    end
  endgenerate

  assign w_bad_digit = |w_digit_bad;

  logic r_err;

  // The flag is set by a rejected start and cleared by a normal completion.
  // Between those events it keeps its value; it is only meaningful with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == c_idle && start && w_bad_digit) begin
      r_err <= 1'b1;
    end else if (r_state == c_shift && w_last) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  assign w_bad_digit = 1'b0;
  assign err         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (start && !w_bad_digit) begin
          w_next_state = c_shift;
        end
      end
      c_shift: begin
        if (w_last) begin
          w_next_state = c_idle;
        end
      end
      default: w_next_state = c_idle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == c_shift);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_bin_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            if (w_bad_digit) begin
              r_done    <= 1'b1;
              r_bin_out <= '0;
            end else begin
              r_bcd <= bcd_in;
              r_bin <= '0;
              r_cnt <= '0;
            end
          end
        end
        c_shift: begin
          r_bcd <= w_cor_bcd;
          r_bin <= w_sh_bin;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_bin_out <= w_sh_bin;
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done    = r_done;
  assign bin_out = r_bin_out;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin_seq
// Purpose  : Self-checking bench for bcd_to_bin_seq (DIGITS=3, BIN_W=10).
//            Expected results come from a decimal-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [11:0]       bcd_in;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: decimal value of a packed BCD word.
  function automatic int bcd_value(input logic [11:0] v);
    int s = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      s += int'(v[4*i +: 4]) * p;
      p *= 10;
    end
    return s;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] r;
    int m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Launch one conversion and observe it up to the done pulse (bounded).
  // lat counts clocks from the start edge to the done cycle, minus 1 edge.
  task automatic convert(input logic [11:0] v, output logic [BIN_W-1:0] res,
                         output int lat, output int busy_cycles, output bit e,
                         output bit held, output bit busy_at_done);
    logic [BIN_W-1:0] prev;
    @(negedge clk);
    prev   = bin_out;
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cycles = 0;
    held = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      if (bin_out !== prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = bin_out;
    e = err;
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bcd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (bin_out !== '0) begin errors++; $display("FAIL reset_bin_out: got %0d expected 0", bin_out); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_basic();
    logic [11:0] vals [3] = '{12'h999, 12'h000, 12'h255};
    int          exps [3] = '{999, 0, 255};
    logic [BIN_W-1:0] res;
    int lat, bc;
    bit e, h, bd;
    for (int i = 0; i < 3; i++) begin
      convert(vals[i], res, lat, bc, e, h, bd);
      checks++; if (lat != BIN_W) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, BIN_W); end
      checks++; if (bc != BIN_W) begin errors++; $display("FAIL basic_busy_cycles[%0d]: got %0d expected %0d", i, bc, BIN_W); end
      checks++; if (int'(res) != exps[i]) begin errors++; $display("FAIL basic_result[%0d]: got %0d expected %0d", i, res, exps[i]); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err[%0d]: got %b expected 0", i, e); end
      checks++; if (bd !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done[%0d]: got %b expected 0", i, bd); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse[%0d]: got %b expected 0", i, done); end
      checks++; if (int'(bin_out) != exps[i]) begin errors++; $display("FAIL basic_hold[%0d]: got %0d expected %0d", i, bin_out, exps[i]); end
    end
  endtask

  task automatic test_random();
    logic [BIN_W-1:0] res;
    int lat, bc, n;
    bit e, h, bd;
    for (int i = 0; i < 150; i++) begin
      n = int'($urandom_range(0, 999));
      convert(to_bcd(n), res, lat, bc, e, h, bd);
      checks++; if (int'(res) != n || lat != BIN_W) begin errors++; $display("FAIL random_result: got %0d (lat %0d) expected %0d (lat %0d)", res, lat, n, BIN_W); end
      checks++; if (!h) begin errors++; $display("FAIL random_bin_out_held: got changing bin_out expected stable while busy"); end
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, lat, r1, r2;
    @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h123;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      // Extra requests while busy must be ignored.
      if (lat >= 2 && lat <= 4) begin start = 1'b1; bcd_in = 12'h777; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    t1 = cyc;
    r1 = int'(bin_out);
    start = 1'b1;
    bcd_in = 12'h456;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    t2 = cyc;
    r2 = int'(bin_out);
    checks++; if (r1 != 123) begin errors++; $display("FAIL b2b_first: got %0d expected 123", r1); end
    checks++; if (r2 != 456) begin errors++; $display("FAIL b2b_second: got %0d expected 456", r2); end
    checks++; if (t2 - t1 != BIN_W + 1) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, BIN_W + 1); end
  endtask

  task automatic test_reset_mid();
    logic [BIN_W-1:0] res;
    int lat, bc, seen;
    bit e, h, bd;
    @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h789;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bin_out !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got busy=%b done=%b err=%b bin_out=%0d expected all 0", busy, done, err, bin_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d pulses expected 0", seen); end
    convert(12'h042, res, lat, bc, e, h, bd);
    checks++; if (int'(res) != 42 || lat != BIN_W) begin errors++; $display("FAIL after_reset_result: got %0d (lat %0d) expected 42 (lat %0d)", res, lat, BIN_W); end
  endtask

  task automatic test_invalid();
    logic [BIN_W-1:0] res;
    logic [11:0] v;
    int lat, bc;
    bit e, h, bd;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) v = 12'h9A5;
      else begin
        v = to_bcd(int'($urandom_range(0, 999)));
        v[4*(i % DIGITS) +: 4] = 4'($urandom_range(10, 15));
      end
      convert(v, res, lat, bc, e, h, bd);
`ifdef BCD_CHECK_EN
      checks++; if (lat != 0) begin errors++; $display("FAIL invalid_latency[%0d]: got %0d expected 0", i, lat); end
      checks++; if (bc != 0 || bd !== 1'b0) begin errors++; $display("FAIL invalid_busy[%0d]: got %0d cycles expected 0", i, bc); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL invalid_err[%0d]: got %b expected 1", i, e); end
      checks++; if (res !== '0) begin errors++; $display("FAIL invalid_bin_out[%0d]: got %0d expected 0", i, res); end
`else
      checks++; if (lat != BIN_W) begin errors++; $display("FAIL invalid_latency[%0d]: got %0d expected %0d", i, lat, BIN_W); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL invalid_err[%0d]: got %b expected 0", i, e); end
`endif
    end
    convert(12'h100, res, lat, bc, e, h, bd);
    checks++; if (int'(res) != 100 || lat != BIN_W) begin errors++; $display("FAIL valid_after_invalid: got %0d (lat %0d) expected 100 (lat %0d)", res, lat, BIN_W); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL valid_after_invalid_err: got %b expected 0", e); end
  endtask

  task automatic test_sweep();
    logic [BIN_W-1:0] res;
    logic [11:0] v;
    int lat, bc, exp_v;
    bit e, h, bd;
    for (int n = 0; n < 1000; n++) begin
      v = to_bcd(n);
      exp_v = bcd_value(v);
      convert(v, res, lat, bc, e, h, bd);
      checks++; if (int'(res) != exp_v || lat != BIN_W) begin
        errors++; $display("FAIL sweep[%03h]: got %0d (lat %0d) expected %0d (lat %0d)", v, res, lat, exp_v, BIN_W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_invalid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
